// File: rtl/vsc_pkg.sv
// vsc_pkg: shared state encoding, default MISR taps and the MISR step function
package vsc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} vsc_state_e;
  localparam logic [15:0] VSC_POLY = 16'h1021;
  function automatic logic [63:0] misr_step(input logic [63:0] sig, input logic [63:0] data,
                                            input logic [63:0] poly, input int w = 16);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return (((sig << 1) ^ (sig[w-1] ? poly : 64'd0)) ^ data) & m;
  endfunction
endpackage

// File: rtl/vector_stream_checker_if.sv
// vector_stream_checker_if: record stream handshake between the logger and the checker
interface vector_stream_checker_if #(parameter int N_WIDTH = 7);
  logic rec_valid;
  logic rec_ready;
  logic [N_WIDTH-1:0] rec_vec;
  logic rec_out;
  modport master(output rec_valid, rec_vec, rec_out, input rec_ready);
  modport slave(input rec_valid, rec_vec, rec_out, output rec_ready);
endinterface

// File: rtl/vsc_misr.sv
// vsc_misr: signature register compacting one data word per enabled cycle
module vsc_misr
  import vsc_pkg::*;
#(
  parameter int W = 16,
  parameter logic [W-1:0] POLY = W'(VSC_POLY)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] data,
  output logic [W-1:0] sig
);
  always_ff @(posedge clk)
    if (rst || clr) sig <= '0;
    else if (en) sig <= W'(misr_step(64'(sig), 64'(data), 64'(POLY), W));
endmodule

// File: rtl/vector_stream_checker.sv
// vector_stream_checker: order-checks and MISR-compacts an exhaustive vector/response stream
module vector_stream_checker
  import vsc_pkg::*;
#(
  parameter int N_WIDTH = 7,
  parameter int SIG_WIDTH = 16,
  parameter logic [SIG_WIDTH-1:0] POLY = SIG_WIDTH'(VSC_POLY)
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SIG_WIDTH-1:0] expected_sig,
  vector_stream_checker_if.slave rec,
  output logic [N_WIDTH:0]     count,
  output logic [SIG_WIDTH-1:0] signature,
  output logic                 seq_error,
  output logic [N_WIDTH:0]     err_index,
  output logic                 done,
  output logic                 pass
);
  if (N_WIDTH + 1 > SIG_WIDTH) begin : g_bad_width
    $error("SIG_WIDTH must be at least N_WIDTH+1");
  end
  localparam logic [N_WIDTH:0] LAST = (N_WIDTH+1)'((1 << N_WIDTH) - 1);
  vsc_state_e state, state_n;
  logic acc, clr;
  assign acc = rec.rec_valid && rec.rec_ready;
  assign clr = (state == IDLE || state == DONE) && start;
  always_ff @(posedge CK) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? RUN : state;
      RUN:        state_n = (acc && count == LAST) ? CHECK : RUN;
      CHECK:      state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge CK)
    if (reset) begin
      rec.rec_ready <= 1'b0;
      count <= '0;
      seq_error <= 1'b0;
      err_index <= '0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      rec.rec_ready <= state_n == RUN;
      if (clr) begin
        count <= '0;
        seq_error <= 1'b0;
        err_index <= '0;
        done <= 1'b0;
        pass <= 1'b0;
      end else if (acc) begin
        count <= count + 1'b1;
        if (rec.rec_vec != count[N_WIDTH-1:0] && !seq_error) begin
          seq_error <= 1'b1;
          err_index <= count;
        end
      end
      if (state == CHECK) begin
        pass <= signature == expected_sig && !seq_error;
        done <= 1'b1;
      end
    end
  vsc_misr #(.W(SIG_WIDTH), .POLY(POLY)) u_misr (
    .clk(CK),
    .rst(reset),
    .clr(clr),
    .en(acc),
    .data(SIG_WIDTH'({rec.rec_vec, rec.rec_out})),
    .sig(signature)
  );
endmodule

// File: doc/vector_stream_checker.md
# vector_stream_checker

Consumes the record stream of an exhaustive-pattern simulation: one record per applied input vector, holding the vector and the single-bit DUT response. Checks that vectors arrive in strict counting order 0 … 2^N_WIDTH−1, compacts every record into a MISR signature, and compares the final signature against a golden value. It is the consuming end of the vector/response logging path in the Trojan-detection flow. It lets a benchmark run be judged pass/fail in hardware instead of by diffing text dumps.

## Interface
- N_WIDTH, 7, vector width; a run is exactly 2^N_WIDTH records.
- SIG_WIDTH, 16, MISR width; N_WIDTH+1 ≤ SIG_WIDTH is required and is checked at elaboration.
- POLY, 16'h1021, MISR feedback taps (low SIG_WIDTH bits used).

Ports:
- CK  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset (fixed).
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- expected_sig  in  SIG_WIDTH  golden signature; sampled in CHECK.
- rec_valid  in  1  record present.
- rec_ready  out  1  checker accepts a record this cycle.
- rec_vec  in  N_WIDTH  applied input vector.
- rec_out  in  1  DUT response bit for rec_vec.
- count  out  N_WIDTH+1  records accepted this run.
- signature  out  SIG_WIDTH  current MISR value.
- seq_error  out  1  sticky; a vector arrived out of order.
- err_index  out  N_WIDTH+1  count value at the first out-of-order record.
- done  out  1  run complete; result valid.
- pass  out  1  valid while done: signature==expected_sig and !seq_error.

## Operation
- FSM states: IDLE, RUN, CHECK, DONE.
  - IDLE → RUN on start.
  - RUN → CHECK on the accept that makes count == 2^N_WIDTH.
  - CHECK → DONE unconditionally.
  - DONE → RUN on start.
- Entering RUN clears count, signature, seq_error, err_index, done and pass.
- rec_ready is 1 only in RUN. Accept = rec_valid && rec_ready. Records offered outside RUN are not consumed.
- Per accept:
  - data = {rec_vec, rec_out}, zero-extended to SIG_WIDTH.
  - sig_next = (sig << 1) ^ (sig[MSB] ? POLY : 0) ^ data.
  - count increments.
  - If rec_vec != count[N_WIDTH-1:0] and seq_error is 0: set seq_error and latch err_index = count.
  - Later mismatches change neither seq_error nor err_index.
- Out-of-order records are still compacted and counted. The run length is always 2^N_WIDTH accepts.
- CHECK registers pass = (signature == expected_sig) && !seq_error.
- start is ignored in RUN and CHECK.
- reset at any point, including mid-run, returns the block to IDLE with all outputs at reset values. No partial state survives.

## Timing
- Reset values: rec_ready 0, count 0, signature 0, seq_error 0, err_index 0, done 0, pass 0.
- All outputs are registered.
- A start sampled in cycle t puts the block in RUN at t+1, with rec_ready=1 from t+1.
- An accept in cycle t updates count, signature and seq_error at t+1.
- Last accept in cycle t: CHECK at t+1, then done=1 and pass valid at t+2.
- done and pass hold until the next start or reset.
- Throughput is one record per cycle with no bubbles. rec_valid may deassert arbitrarily; count only advances on accept.
- count is N_WIDTH+1 bits, so the value 2^N_WIDTH is representable. It never wraps within a run.

## Structure
- Shared package vsc_pkg holds:
  - the state enum (IDLE/RUN/CHECK/DONE);
  - the default POLY constant;
  - a function misr_step(sig, data, poly), also used by the bench reference model.
- One sub-module, vsc_misr: the signature register with clear and enable. The top level holds the FSM, counter, order check and compare.

## Test plan
- Small config (N_WIDTH=2, SIG_WIDTH=4, POLY=4'h3), rec_out all 0:
  - records vec 0,1,2,3 back-to-back with expected_sig=4'h6 → signature 4'h6, count 4, pass=1, done 2 cycles after the last accept;
  - the same run with expected_sig=4'h7 → pass=0, seq_error=0.
- Default config, 128 in-order records with rec_out = vec[0] → count=128, seq_error=0. Signature must equal the misr_step reference model; pass=1 when expected_sig is the model value.
- Default config, vectors 5 and 6 swapped → seq_error=1, err_index=5, pass=0, count=128, done=1.
- rec_valid toggled randomly at 50% over a full default run → identical final signature to the back-to-back run, with no extra or lost accepts.
- Reset at count=40 → all outputs 0, state IDLE. A following start plus a full run gives a result identical to an unreset run.
- start pulsed mid-RUN and records offered in IDLE → no effect: rec_ready stays 0 in IDLE and count is unchanged.
